// File: rtl/matrix_port_arbiter.sv
// Shares one mn_matrix access port between the loader (port 0) and the LU solver (port 1):
// round-robin with burst lock, bounds checking and fixed-latency read-return routing.
module matrix_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m_dim,
    input  logic [ADDR_W-1:0] n_dim,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] m_addr0,
    input  logic [ADDR_W-1:0] m_addr1,
    input  logic [ADDR_W-1:0] n_addr0,
    input  logic [ADDR_W-1:0] n_addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_m_addr,
    output logic [ADDR_W-1:0] mem_n_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {FREE, OWNED0, OWNED1} state_e;

    state_e state_q, state_d;
    logic   rr_q, rr_d;
    logic   locked;

    logic              acc0, acc1, accept;
    logic              sel_we, oob;
    logic [ADDR_W-1:0] sel_m, sel_n;
    logic [DATA_W-1:0] sel_wd;

    logic              mw_q, mr_q, err0_q, err1_q;
    logic [ADDR_W-1:0] ma_q, na_q;
    logic [DATA_W-1:0] din_q;

    logic              t1_v_q, t1_id_q, t1_err_q;
    logic              t2_v_q, t2_id_q, t2_err_q;
    logic [DATA_W-1:0] hold0_q, hold1_q;
    logic [DATA_W-1:0] ret_data;

    // A dropped lock hands the current cycle straight back to free arbitration.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        locked  = (state_q == OWNED0 && lock0) ||
                  (state_q == OWNED1 && lock1);
        if (locked) begin
            gnt0 = (state_q == OWNED0) && req0;
            gnt1 = (state_q == OWNED1) && req1;
        end else if (req0 && req1) begin
            gnt0 = ~rr_q;
            gnt1 = rr_q;
            rr_d = ~rr_q;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
        if (gnt0 && lock0) begin
            state_d = OWNED0;
        end else if (gnt1 && lock1) begin
            state_d = OWNED1;
        end else if (!locked) begin
            state_d = FREE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FREE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    assign acc0   = req0 & gnt0;
    assign acc1   = req1 & gnt1;
    assign accept = acc0 | acc1;
    assign sel_we = acc1 ? we1 : we0;
    assign sel_m  = acc1 ? m_addr1 : m_addr0;
    assign sel_n  = acc1 ? n_addr1 : n_addr0;
    assign sel_wd = acc1 ? wdata1 : wdata0;
    assign oob    = (sel_m >= m_dim) || (sel_n >= n_dim);

    // Out-of-bounds reads still travel the tag pipe so return latency stays fixed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mw_q     <= 1'b0;
            mr_q     <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            ma_q     <= '0;
            na_q     <= '0;
            din_q    <= '0;
            t1_v_q   <= 1'b0;
            t1_id_q  <= 1'b0;
            t1_err_q <= 1'b0;
            t2_v_q   <= 1'b0;
            t2_id_q  <= 1'b0;
            t2_err_q <= 1'b0;
            hold0_q  <= '0;
            hold1_q  <= '0;
        end else begin
            mw_q     <= accept & sel_we & ~oob;
            mr_q     <= accept & ~sel_we & ~oob;
            err0_q   <= acc0 & oob;
            err1_q   <= acc1 & oob;
            if (accept) begin
                ma_q  <= sel_m;
                na_q  <= sel_n;
                din_q <= sel_wd;
            end
            t1_v_q   <= accept & ~sel_we;
            t1_id_q  <= acc1;
            t1_err_q <= oob;
            t2_v_q   <= t1_v_q;
            t2_id_q  <= t1_id_q;
            t2_err_q <= t1_err_q;
            if (rvalid0) hold0_q <= ret_data;
            if (rvalid1) hold1_q <= ret_data;
        end
    end

    assign ret_data   = t2_err_q ? '0 : mem_dout;
    assign rvalid0    = t2_v_q & ~t2_id_q;
    assign rvalid1    = t2_v_q & t2_id_q;
    assign rdata0     = rvalid0 ? ret_data : hold0_q;
    assign rdata1     = rvalid1 ? ret_data : hold1_q;
    assign err0       = err0_q;
    assign err1       = err1_q;
    assign mem_write  = mw_q;
    assign mem_read   = mr_q;
    assign mem_m_addr = ma_q;
    assign mem_n_addr = na_q;
    assign mem_din    = din_q;

endmodule

// File: tb/tb_matrix_port_arbiter.sv
// Bench for matrix_port_arbiter: bench-side matrix store, cycle-indexed
// expectation model checked every cycle, plus directed literal checks.
module tb_matrix_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  m_dim = 8'd4, n_dim = 8'd4;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
    logic [7:0]  m_addr0 = 0, m_addr1 = 0, n_addr0 = 0, n_addr1 = 0;
    logic [31:0] wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_write, mem_read;
    logic [7:0]  mem_m_addr, mem_n_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    matrix_port_arbiter #(.DATA_W(32), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .m_dim(m_dim), .n_dim(n_dim),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .m_addr0(m_addr0), .m_addr1(m_addr1),
        .n_addr0(n_addr0), .n_addr1(n_addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_m_addr(mem_m_addr), .mem_n_addr(mem_n_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Bench-side matrix store (the mn_matrix stand-in) and its scoreboard copy.
    logic [31:0] mem [16][16];
    logic [31:0] sb  [16][16];

    function automatic logic [31:0] init_val(int m, int n);
        return 32'hA000_0000 | 32'(m * 256 + n);
    endfunction

    always @(posedge clk) begin
        if (mem_write) mem[mem_m_addr[3:0]][mem_n_addr[3:0]] = mem_din;
        if (mem_read) mem_dout <= mem[mem_m_addr[3:0]][mem_n_addr[3:0]];
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Expectations indexed by cycle number.
    bit          e_mw[4096], e_mr[4096], e_err0[4096], e_err1[4096];
    bit          e_rv0[4096], e_rv1[4096];
    logic [7:0]  e_ma[4096], e_na[4096];
    logic [31:0] e_din[4096], e_rd0[4096], e_rd1[4096];

    int          owner = -1;
    int          pref = 0;
    logic [31:0] hold0 = 0, hold1 = 0;
    bit          x_mw, x_mr, x_e0, x_e1, x_v0, x_v1;
    bit          lk, g0, g1, p, a_we, bad;
    logic [7:0]  a_m, a_n;
    logic [31:0] a_d;

    always @(negedge clk) begin
        if (reset) begin
            owner = -1;
            pref  = 0;
            hold0 = 0;
            hold1 = 0;
            x_mw = 0; x_mr = 0; x_e0 = 0; x_e1 = 0; x_v0 = 0; x_v1 = 0;
        end else begin
            x_mw = e_mw[cyc];  x_mr = e_mr[cyc];
            x_e0 = e_err0[cyc]; x_e1 = e_err1[cyc];
            x_v0 = e_rv0[cyc]; x_v1 = e_rv1[cyc];
        end
        chk1("mem_write", mem_write, x_mw);
        chk1("mem_read", mem_read, x_mr);
        if (x_mw || x_mr) begin
            chkw("mem_m_addr", 32'(mem_m_addr), 32'(e_ma[cyc]));
            chkw("mem_n_addr", 32'(mem_n_addr), 32'(e_na[cyc]));
        end
        if (x_mw) chkw("mem_din", mem_din, e_din[cyc]);
        chk1("err0", err0, x_e0);
        chk1("err1", err1, x_e1);
        chk1("rvalid0", rvalid0, x_v0);
        chk1("rvalid1", rvalid1, x_v1);
        if (x_v0) hold0 = e_rd0[cyc];
        if (x_v1) hold1 = e_rd1[cyc];
        chkw("rdata0", rdata0, hold0);
        chkw("rdata1", rdata1, hold1);

        // Grant rules: a locked owner keeps the port; otherwise single
        // requester wins, contention goes to the preferred side.
        lk = (owner == 0 && lock0) || (owner == 1 && lock1);
        if (lk) begin
            g0 = (owner == 0) && req0;
            g1 = (owner == 1) && req1;
        end else if (req0 && req1) begin
            g0 = (pref == 0);
            g1 = (pref == 1);
        end else begin
            g0 = req0;
            g1 = req1;
        end
        chk1("gnt0", gnt0, g0);
        chk1("gnt1", gnt1, g1);

        e_mw[cyc+1] = 0; e_mr[cyc+1] = 0;
        e_err0[cyc+1] = 0; e_err1[cyc+1] = 0;
        e_rv0[cyc+2] = 0; e_rv1[cyc+2] = 0;
        if (reset) begin
            e_rv0[cyc+1] = 0;
            e_rv1[cyc+1] = 0;
        end else begin
            if (!lk && req0 && req1) pref = g0 ? 1 : 0;
            if (g0 && lock0) owner = 0;
            else if (g1 && lock1) owner = 1;
            else if (!lk) owner = -1;
            if (g0 || g1) begin
                p    = g1;
                a_we = p ? we1 : we0;
                a_m  = p ? m_addr1 : m_addr0;
                a_n  = p ? n_addr1 : n_addr0;
                a_d  = p ? wdata1 : wdata0;
                bad  = (a_m >= m_dim) || (a_n >= n_dim);
                if (bad) begin
                    if (p) e_err1[cyc+1] = 1;
                    else   e_err0[cyc+1] = 1;
                end else begin
                    e_mw[cyc+1] = a_we;
                    e_mr[cyc+1] = !a_we;
                    e_ma[cyc+1] = a_m;
                    e_na[cyc+1] = a_n;
                    e_din[cyc+1] = a_d;
                    if (a_we) sb[a_m[3:0]][a_n[3:0]] = a_d;
                end
                if (!a_we) begin
                    if (p) begin
                        e_rv1[cyc+2] = 1;
                        e_rd1[cyc+2] = bad ? 32'h0 : sb[a_m[3:0]][a_n[3:0]];
                    end else begin
                        e_rv0[cyc+2] = 1;
                        e_rd0[cyc+2] = bad ? 32'h0 : sb[a_m[3:0]][a_n[3:0]];
                    end
                end
            end
        end
        cyc++;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    endtask

    task automatic set0(input logic w, input logic [7:0] m, input logic [7:0] n,
                        input logic [31:0] d);
        req0 = 1; we0 = w; m_addr0 = m; n_addr0 = n; wdata0 = d;
    endtask

    task automatic set1(input logic w, input logic [7:0] m, input logic [7:0] n,
                        input logic [31:0] d);
        req1 = 1; we1 = w; m_addr1 = m; n_addr1 = n; wdata1 = d;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                mem[i][j] = init_val(i, j);
                sb[i][j]  = init_val(i, j);
            end
        end
        @(negedge clk);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk1("rst_rvalid0", rvalid0, 1'b0);
        chkw("rst_rdata0", rdata0, 32'h0);
        nxt();
        reset = 0;
        nxt();

        // Write then read back (2,3).
        set0(1, 8'd2, 8'd3, 32'hDEAD_BEEF);
        @(negedge clk); chk1("wr_gnt0", gnt0, 1'b1);
        nxt(); idle();
        @(negedge clk);
        chk1("wr_strobe", mem_write, 1'b1);
        chkw("wr_m_addr", 32'(mem_m_addr), 32'd2);
        chkw("wr_n_addr", 32'(mem_n_addr), 32'd3);
        chkw("wr_din", mem_din, 32'hDEAD_BEEF);
        nxt(); set0(0, 8'd2, 8'd3, 32'h0);
        @(negedge clk); chk1("rd_gnt0", gnt0, 1'b1);
        nxt(); idle();
        @(negedge clk); chk1("rd_strobe", mem_read, 1'b1);
        nxt();
        @(negedge clk);
        chk1("rd_rvalid0", rvalid0, 1'b1);
        chkw("rd_rdata0", rdata0, 32'hDEAD_BEEF);

        // Contention without lock alternates.
        nxt();
        set0(0, 8'd0, 8'd0, 32'h0);
        set1(0, 8'd1, 8'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("rr_gnt0", gnt0, (i % 2) == 0);
            chk1("rr_gnt1", gnt1, (i % 2) == 1);
            nxt();
        end
        idle();
        nxt();

        // Port 1 burst under lock while port 0 waits.
        for (int i = 0; i < 5; i++) begin
            set1(1, 8'd3, 8'd3, 32'h1111_0000 + i);
            lock1 = 1;
            if (i > 0) set0(0, 8'd0, 8'd0, 32'h0);
            @(negedge clk);
            chk1("lock_gnt0", gnt0, 1'b0);
            chk1("lock_gnt1", gnt1, 1'b1);
            nxt();
        end
        req1 = 0; lock1 = 0;
        @(negedge clk); chk1("unlock_gnt0", gnt0, 1'b1);
        nxt(); idle();

        // Out-of-bounds read on the row boundary.
        set0(0, 8'd4, 8'd0, 32'h0);
        nxt(); idle();
        @(negedge clk);
        chk1("oob_no_read", mem_read, 1'b0);
        chk1("oob_err0", err0, 1'b1);
        nxt();
        @(negedge clk);
        chk1("oob_rvalid0", rvalid0, 1'b1);
        chkw("oob_rdata0", rdata0, 32'h0);
        nxt();

        // Further boundaries: last valid cell, column edge, zero dims.
        set1(0, 8'd3, 8'd3, 32'h0);
        nxt(); idle();
        set1(1, 8'd0, 8'd4, 32'h5555_5555);
        nxt(); idle();
        m_dim = 8'd0;
        set0(0, 8'd0, 8'd0, 32'h0);
        nxt(); idle();
        m_dim = 8'd4; n_dim = 8'd0;
        set1(0, 8'd1, 8'd1, 32'h0);
        nxt(); idle();
        n_dim = 8'd4;

        // Port 0 locked write burst, port 1 joins after the first grant.
        set0(1, 8'd2, 8'd0, 32'hCAFE_0000); lock0 = 1;
        nxt();
        set0(1, 8'd2, 8'd1, 32'hCAFE_0001); lock0 = 1;
        set1(0, 8'd2, 8'd0, 32'h0);
        nxt();
        req0 = 0; lock0 = 0;
        nxt(); idle();
        nxt();

        // Interleaved back-to-back reads.
        set0(0, 8'd1, 8'd1, 32'h0);
        nxt(); idle();
        set1(0, 8'd1, 8'd2, 32'h0);
        nxt(); idle();
        set0(0, 8'd0, 8'd1, 32'h0);
        @(negedge clk);
        chk1("il_rvalid0_a", rvalid0, 1'b1);
        chkw("il_rdata0_a", rdata0, 32'hA000_0101);
        nxt(); idle();
        @(negedge clk);
        chk1("il_rvalid1", rvalid1, 1'b1);
        chkw("il_rdata1", rdata1, 32'hA000_0102);
        nxt();
        @(negedge clk);
        chk1("il_rvalid0_b", rvalid0, 1'b1);
        chkw("il_rdata0_b", rdata0, 32'hA000_0001);
        chkw("il_rdata1_hold", rdata1, 32'hA000_0102);
        nxt();

        // Reset right after a read accept; preference restarts at port 0.
        set0(0, 8'd0, 8'd0, 32'h0);
        set1(0, 8'd0, 8'd1, 32'h0);
        @(negedge clk); chk1("pre_rst_gnt0", gnt0, 1'b1);
        nxt(); idle();
        set0(0, 8'd1, 8'd1, 32'h0);
        nxt(); idle();
        reset = 1;
        @(negedge clk);
        chk1("rst_rvalid0_a", rvalid0, 1'b0);
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        nxt();
        reset = 0;
        set0(0, 8'd0, 8'd0, 32'h0);
        set1(0, 8'd0, 8'd1, 32'h0);
        @(negedge clk);
        chk1("rst_rvalid0_b", rvalid0, 1'b0);
        chk1("post_rst_gnt0", gnt0, 1'b1);
        chk1("post_rst_gnt1", gnt1, 1'b0);
        nxt(); idle();
        repeat (4) nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
